// File: rtl/csr_register_bank.sv
// Avalon-MM control/status register bank for the custom image-processing core.
// Holds image geometry, SDRAM window and filter settings. Validates and issues a
// level start, captures completion into DONE/irq, and counts busy cycles.
module csr_register_bank #(
  parameter int ADDR_W   = 4,
  parameter int CFG_W    = 13,
  parameter int SDRAM_AW = 26
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  output logic                irq,
  input  logic                finish_flag,
  output logic                start_control,
  output logic [CFG_W-1:0]    image_width,
  output logic [CFG_W-1:0]    image_height,
  output logic [SDRAM_AW-1:0] start_addr_sdram,
  output logic [SDRAM_AW-1:0] finish_addr_sdram,
  output logic [1:0]          filter_mode,
  output logic [7:0]          beta_value,
  output logic [31:0]         white
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state, state_nxt;
  logic        irq_en;
  logic        cfg_err;
  logic [31:0] cycle_count;
  logic [31:0] rd_mux;
  logic        start_req, done_clr, cfg_wr_en, cfg_ok;
  logic        start_ok, start_bad;
  logic        busy, done;

  // DONE and BUSY are the FSM state itself, so they can never disagree with it
  assign busy          = (state == S_BUSY);
  assign done          = (state == S_DONE);
  assign start_control = busy;

  assign start_req = avs_write && (avs_address == ADDR_W'(0)) && avs_writedata[0];
  assign done_clr  = avs_write && (avs_address == ADDR_W'(1)) && avs_writedata[1];
  // Configuration is frozen while the core is running
  assign cfg_wr_en = avs_write && !busy;

  // Bayer tiles need even dimensions of at least 2, and source/destination must differ
  assign cfg_ok = (image_width  >= CFG_W'(2)) && !image_width[0] &&
                  (image_height >= CFG_W'(2)) && !image_height[0] &&
                  (start_addr_sdram != finish_addr_sdram);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and start accept/reject decisions
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          if (cfg_ok) begin
            state_nxt = S_BUSY;
            start_ok  = 1'b1;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_BUSY: begin
        // finish wins over any DONE clear in the same cycle: clear has no effect here
        if (finish_flag) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start_req) begin
          if (cfg_ok) begin
            state_nxt = S_BUSY;
            start_ok  = 1'b1;
          end else begin
            start_bad = 1'b1;
          end
        end else if (done_clr) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Configuration registers, writable only outside BUSY
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      image_width       <= '0;
      image_height      <= '0;
      start_addr_sdram  <= '0;
      finish_addr_sdram <= '0;
      filter_mode       <= '0;
      beta_value        <= '0;
      white             <= 32'hFFFF_FFFF;
    end else if (cfg_wr_en) begin
      case (avs_address)
        ADDR_W'(2): image_width       <= avs_writedata[CFG_W-1:0];
        ADDR_W'(3): image_height      <= avs_writedata[CFG_W-1:0];
        ADDR_W'(4): start_addr_sdram  <= avs_writedata[SDRAM_AW-1:0];
        ADDR_W'(5): finish_addr_sdram <= avs_writedata[SDRAM_AW-1:0];
        ADDR_W'(6): filter_mode       <= avs_writedata[1:0];
        ADDR_W'(7): beta_value        <= avs_writedata[7:0];
        ADDR_W'(8): white             <= avs_writedata;
        default: ;
      endcase
    end
  end

  // IRQ enable (always writable) and config error flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      irq_en  <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_W'(0))) irq_en <= avs_writedata[1];
      if (start_ok)       cfg_err <= 1'b0;
      else if (start_bad) cfg_err <= 1'b1;
    end
  end

  // Busy-cycle counter: cleared on an accepted start, saturating while BUSY
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                         cycle_count <= '0;
    else if (start_ok)                  cycle_count <= '0;
    else if (busy && cycle_count != '1) cycle_count <= cycle_count + 32'd1;
  end

  // Registered interrupt
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) irq <= 1'b0;
    else        irq <= done & irq_en;
  end

  // Read mux over current (pre-write) register values
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_W'(0): rd_mux = {30'd0, irq_en, 1'b0};
      ADDR_W'(1): rd_mux = {29'd0, cfg_err, done, busy};
      ADDR_W'(2): rd_mux = 32'(image_width);
      ADDR_W'(3): rd_mux = 32'(image_height);
      ADDR_W'(4): rd_mux = 32'(start_addr_sdram);
      ADDR_W'(5): rd_mux = 32'(finish_addr_sdram);
      ADDR_W'(6): rd_mux = {30'd0, filter_mode};
      ADDR_W'(7): rd_mux = {24'd0, beta_value};
      ADDR_W'(8): rd_mux = white;
      ADDR_W'(9): rd_mux = cycle_count;
      default:    rd_mux = '0;
    endcase
  end

  // Fixed one-cycle read response
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdata      <= avs_read ? rd_mux : 32'd0;
      avs_readdatavalid <= avs_read;
    end
  end

endmodule
